spare_sram_array: RTL and testbench
===================================

Name: spare_sram_array

Overview:
- Parametrised spare-memory array for the BISR memory controller: NUM_SPARE independent single-port banks of DEPTH x DW, selected by a bank index, replacing fixed 25 x 128x8 spare instances.
- Adds a valid/ready request port, a registered read pipeline, per-bank enable masking with error reporting, and a hardware zero-fill init sequencer, so remapped words never return stale data.
- Sits between the BISR remap logic, which supplies the bank select, and the main memory read mux.

Parameters:
- NUM_SPARE, 25, number of spare banks.
- AW, 7, word address width; DEPTH = 2**AW.
- DW, 8, data width.
- SEL_W, 5, bank select width; must satisfy 2**SEL_W >= NUM_SPARE.
- ERR_W, 8, width of the saturating error counter.

Ports:
- CLK  input  1  clock.
- RST  input  1  reset.
- INIT_REQ  input  1  pulse: restart zero-fill of all banks.
- BANK_EN  input  NUM_SPARE  per-bank enable mask (bit i = bank i usable).
- REQ_VALID  input  1  request valid.
- REQ_READY  output  1  array can accept request.
- REQ_WE  input  1  1 = write, 0 = read.
- REQ_SEL  input  SEL_W  target bank index.
- REQ_ADDR  input  AW  word address.
- REQ_WDATA  input  DW  write data.
- RSP_VALID  output  1  read response valid (single-cycle pulse).
- RSP_DATA  output  DW  read data.
- RSP_ERR  output  1  qualifies RSP_VALID: access rejected.
- INIT_DONE  output  1  high while array is in RUN.
- ERR_CNT  output  ERR_W  saturating count of rejected accesses.

Behaviour:
- Single clock CLK; RST is synchronous, active-high; all state updates on the rising edge of CLK.
- Reset values: state=INIT, init counter=0, REQ_READY=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, INIT_DONE=0, ERR_CNT=0. Memory contents are not reset; INIT clears them.

FSM states:
- INIT:
  - Each cycle, write 0 to word init_cnt of every bank in parallel, regardless of BANK_EN; init_cnt increments.
  - When init_cnt = DEPTH-1 is written, next state = RUN.
  - Exactly DEPTH clear cycles run after the first edge with RST low.
- RUN:
  - INIT_DONE=1.
  - INIT_REQ=1 moves the FSM to INIT next cycle with init_cnt=0, and INIT_DONE drops the same edge.

Handshake:
- REQ_READY = (state==RUN) && !INIT_REQ, combinational.
- A transfer happens when REQ_VALID && REQ_READY.
- REQ_VALID held while not ready is not lost; the requester keeps it asserted.
- Requests in INIT are never accepted.

Legality:
- An access is legal iff REQ_SEL < NUM_SPARE && BANK_EN[REQ_SEL].
- Legal write: the word is updated at the accept edge. No response.
- Legal read: one cycle after the accept edge, RSP_VALID=1, RSP_DATA=mem[SEL][ADDR], RSP_ERR=0.
- Read-after-write to the same word in the next cycle returns the new data.
- Illegal write: dropped, no response, ERR_CNT+1.
- Illegal read: RSP_VALID=1, RSP_DATA=0, RSP_ERR=1 next cycle, ERR_CNT+1.
- ERR_CNT saturates at 2**ERR_W-1. It is cleared only by RST, not by INIT_REQ.

Response path:
- No backpressure; one read accepted per cycle gives back-to-back RSP_VALID.
- RSP_DATA holds its last value when RSP_VALID=0.

Boundaries:
- A read accepted in the cycle before INIT_REQ still returns its response, with pre-clear data, while INIT runs.
- INIT_REQ asserted during INIT restarts init_cnt at 0.
- RST asserted mid-INIT or mid-RUN returns to reset values at that edge. A pending response is cancelled: RSP_VALID=0 next cycle.
- BANK_EN is sampled at the accept edge only; changing it later does not affect in-flight responses.
- Address wrap: none. REQ_ADDR is exactly AW bits.

Test Plan:
- Release RST, REQ_VALID=0 -> REQ_READY=0 and INIT_DONE=0 for 128 cycles, INIT_DONE=1 on the 128th edge; read bank 24, addr 0x7F -> RSP_DATA=0x00, RSP_ERR=0.
- Write 0xA5 to bank 3, addr 0x10; read it the next cycle -> RSP_VALID one cycle after accept, RSP_DATA=0xA5; back-to-back reads of banks 3 and 4 -> two consecutive RSP_VALID pulses, 0xA5 then 0x00.
- BANK_EN[7]=0: write 0x3C to bank 7, then read bank 7 -> write dropped, RSP_DATA=0x00, RSP_ERR=1, ERR_CNT=2; REQ_SEL=25 read -> RSP_ERR=1, ERR_CNT=3.
- Drive 300 illegal reads with ERR_W=8 -> ERR_CNT saturates at 255 and stays 255.
- Write 0x5A to bank 0, addr 1, then pulse INIT_REQ with a read pending in the same cycle -> REQ_READY=0 that cycle, INIT_DONE low for 128 cycles; reading bank 0, addr 1 afterwards -> 0x00.
- Assert RST one cycle after accepting a read -> RSP_VALID=0 on the following cycle, all outputs at reset values, init restarts from 0.

Source files
------------

// File: rtl/spare_sram_array.sv
`default_nettype none
// ============================================================================
// Module      : spare_sram_array
// Description : Banked spare SRAM array for BISR remapping with valid/ready
//               request port, registered read path and zero-fill sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module spare_sram_array #(
    parameter int NUM_SPARE = 25,
    parameter int AW        = 7,
    parameter int DW        = 8,
    parameter int SEL_W     = 5,
    parameter int ERR_W     = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 INIT_REQ,
    input  logic [NUM_SPARE-1:0] BANK_EN,
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic                 REQ_WE,
    input  logic [SEL_W-1:0]     REQ_SEL,
    input  logic [AW-1:0]        REQ_ADDR,
    input  logic [DW-1:0]        REQ_WDATA,
    output logic                 RSP_VALID,
    output logic [DW-1:0]        RSP_DATA,
    output logic                 RSP_ERR,
    output logic                 INIT_DONE,
    output logic [ERR_W-1:0]     ERR_CNT
);

    localparam int DEPTH = 2**AW;
    localparam int SEL_N = 2**SEL_W;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [AW-1:0]        r_init_cnt;
    logic [AW-1:0]        w_cnt_nxt;

    logic                 w_accept;
    logic                 w_legal;
    logic                 w_rd_accept;
    logic [SEL_N-1:0]     w_en_pad;
    logic [NUM_SPARE-1:0] w_bank_wr;
    logic [DW-1:0]        w_bank_rd [NUM_SPARE];
    logic [DW-1:0]        w_rd_mux;

    logic                 r_rsp_valid;
    logic [DW-1:0]        r_rsp_data;
    logic                 r_rsp_err;
    logic [ERR_W-1:0]     r_err_cnt;

    assign REQ_READY   = (r_state == S_RUN) && !INIT_REQ;
    assign w_accept    = REQ_VALID && REQ_READY;
    assign w_rd_accept = w_accept && !REQ_WE;

    // Selects beyond NUM_SPARE land on zero padding, so they read as disabled.
    always_comb begin
        w_en_pad                = '0;
        w_en_pad[NUM_SPARE-1:0] = BANK_EN;
    end

    assign w_legal = w_en_pad[REQ_SEL];

    // ------------------------------------------------------------------------
    // Init sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_init_cnt;
        case (r_state)
            S_INIT: begin
                if (INIT_REQ) begin
                    w_cnt_nxt = '0;
                end else if (r_init_cnt == AW'(DEPTH - 1)) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_init_cnt + AW'(1);
                end
            end
            S_RUN: begin
                if (INIT_REQ) begin
                    w_state_nxt = S_INIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign INIT_DONE = (r_state == S_RUN);

    // ------------------------------------------------------------------------
    // Spare banks: zero-filled in parallel during INIT, one writer in RUN
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_SPARE; i++) begin : g_bank
        logic [DW-1:0] r_mem [DEPTH];

        assign w_bank_wr[i] = w_accept && REQ_WE && w_legal && (REQ_SEL == SEL_W'(i));

        always_ff @(posedge CLK) begin
            if (!RST) begin
                if (r_state == S_INIT) begin
                    r_mem[r_init_cnt] <= '0;
                end else if (w_bank_wr[i]) begin
                    r_mem[REQ_ADDR] <= REQ_WDATA;
                end
            end
        end

        assign w_bank_rd[i] = r_mem[REQ_ADDR];
    end

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_SPARE; i++) begin
            if (REQ_SEL == SEL_W'(i)) begin
                w_rd_mux = w_bank_rd[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response register and saturating error counter
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_rsp_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_rsp_data <= w_legal ? w_rd_mux : '0;
                r_rsp_err  <= !w_legal;
            end
            if (w_accept && !w_legal && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

    assign RSP_VALID = r_rsp_valid;
    assign RSP_DATA  = r_rsp_data;
    assign RSP_ERR   = r_rsp_err;
    assign ERR_CNT   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_spare_sram_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_spare_sram_array
// Description : Directed scoreboard bench for spare_sram_array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spare_sram_array;

    logic        CLK = 1'b0;
    logic        RST;
    logic        INIT_REQ;
    logic [24:0] BANK_EN;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WE;
    logic [4:0]  REQ_SEL;
    logic [6:0]  REQ_ADDR;
    logic [7:0]  REQ_WDATA;
    logic        RSP_VALID;
    logic [7:0]  RSP_DATA;
    logic        RSP_ERR;
    logic        INIT_DONE;
    logic [7:0]  ERR_CNT;

    int checks   = 0;
    int failures = 0;
    logic [8:0] exp_q [$];

    spare_sram_array dut (
        .CLK       (CLK),
        .RST       (RST),
        .INIT_REQ  (INIT_REQ),
        .BANK_EN   (BANK_EN),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_WE    (REQ_WE),
        .REQ_SEL   (REQ_SEL),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .RSP_VALID (RSP_VALID),
        .RSP_DATA  (RSP_DATA),
        .RSP_ERR   (RSP_ERR),
        .INIT_DONE (INIT_DONE),
        .ERR_CNT   (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Drive one request (entered just after a rising edge), returns just after the accept edge.
    task automatic issue(input logic we, input logic [4:0] sel, input logic [6:0] addr,
                         input logic [7:0] wd, input logic [7:0] ed, input logic ee);
        REQ_VALID = 1'b1;
        REQ_WE    = we;
        REQ_SEL   = sel;
        REQ_ADDR  = addr;
        REQ_WDATA = wd;
        #1;
        chk("req_ready", REQ_READY, 1);
        if (!we) exp_q.push_back({ee, ed});
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        REQ_VALID = 1'b0;
        REQ_WE    = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    // Count rising edges until INIT_DONE, also flagging any ready during init.
    task automatic wait_done(input string tag);
        int n;
        int rdy_hi;
        n      = 0;
        rdy_hi = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
            if (!INIT_DONE && REQ_READY) rdy_hi++;
        end while (!INIT_DONE && n < 400);
        chk(tag, n, 128);
        chk({tag, "_ready_low"}, rdy_hi, 0);
    endtask

    always @(negedge CLK) begin
        if (RSP_VALID) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", RSP_VALID, 0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("rsp_data", RSP_DATA, e[7:0]);
                chk("rsp_err", RSP_ERR, e[8]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        RST       = 1'b1;
        INIT_REQ  = 1'b0;
        BANK_EN   = '1;
        REQ_VALID = 1'b0;
        REQ_WE    = 1'b0;
        REQ_SEL   = '0;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ready", REQ_READY, 0);
        chk("rst_init_done", INIT_DONE, 0);
        chk("rst_rsp_valid", RSP_VALID, 0);
        chk("rst_rsp_data", RSP_DATA, 0);
        chk("rst_rsp_err", RSP_ERR, 0);
        chk("rst_err_cnt", ERR_CNT, 0);

        RST = 1'b0;
        wait_done("init_len");

        // Cleared word in the last bank
        issue(1'b0, 5'd24, 7'h7F, 8'h00, 8'h00, 1'b0);
        chk("rd_latency", RSP_VALID, 1);
        idle();
        chk("rsp_pulse", RSP_VALID, 0);

        // Write then read-after-write
        issue(1'b1, 5'd3, 7'h10, 8'hA5, 8'h00, 1'b0);
        chk("wr_no_rsp", RSP_VALID, 0);
        issue(1'b0, 5'd3, 7'h10, 8'h00, 8'hA5, 1'b0);
        chk("raw_valid", RSP_VALID, 1);
        idle();
        chk("hold_valid", RSP_VALID, 0);
        chk("hold_data", RSP_DATA, 8'hA5);

        // Back-to-back reads of two banks
        issue(1'b0, 5'd3, 7'h10, 8'h00, 8'hA5, 1'b0);
        chk("b2b_first", RSP_VALID, 1);
        issue(1'b0, 5'd4, 7'h10, 8'h00, 8'h00, 1'b0);
        chk("b2b_second", RSP_VALID, 1);
        idle();

        // Disabled bank and out-of-range select
        BANK_EN[7] = 1'b0;
        issue(1'b1, 5'd7, 7'h20, 8'h3C, 8'h00, 1'b0);
        chk("err_wr", ERR_CNT, 1);
        issue(1'b0, 5'd7, 7'h20, 8'h00, 8'h00, 1'b1);
        chk("err_rd", ERR_CNT, 2);
        issue(1'b0, 5'd25, 7'h00, 8'h00, 8'h00, 1'b1);
        idle();
        chk("err_sel25", ERR_CNT, 3);
        BANK_EN[7] = 1'b1;
        issue(1'b0, 5'd7, 7'h20, 8'h00, 8'h00, 1'b0);
        idle();

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            issue(1'b0, 5'd31, 7'(i), 8'h00, 8'h00, 1'b1);
        end
        idle();
        chk("err_sat", ERR_CNT, 255);
        issue(1'b0, 5'd30, 7'h00, 8'h00, 8'h00, 1'b1);
        idle();
        chk("err_sat_hold", ERR_CNT, 255);

        // INIT_REQ with a read pending; earlier read keeps pre-clear data
        issue(1'b1, 5'd0, 7'h01, 8'h5A, 8'h00, 1'b0);
        issue(1'b0, 5'd0, 7'h01, 8'h00, 8'h5A, 1'b0);
        INIT_REQ = 1'b1;
        #1;
        chk("initreq_ready", REQ_READY, 0);
        @(posedge CLK);
        #1;
        INIT_REQ = 1'b0;
        chk("initreq_done_drop", INIT_DONE, 0);
        wait_done("reinit_len");
        exp_q.push_back({1'b0, 8'h00});
        @(posedge CLK);
        #1;
        chk("post_init_valid", RSP_VALID, 1);
        idle();
        chk("err_kept", ERR_CNT, 255);

        // INIT_REQ mid-INIT restarts the sweep
        INIT_REQ = 1'b1;
        @(posedge CLK);
        #1;
        INIT_REQ = 1'b0;
        repeat (50) @(posedge CLK);
        #1;
        INIT_REQ = 1'b1;
        @(posedge CLK);
        #1;
        INIT_REQ = 1'b0;
        wait_done("restart_len");

        // Reset right after an accepted read
        issue(1'b0, 5'd2, 7'h05, 8'h00, 8'h00, 1'b0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("rstmid_valid", RSP_VALID, 0);
        chk("rstmid_data", RSP_DATA, 0);
        chk("rstmid_err", RSP_ERR, 0);
        chk("rstmid_errcnt", ERR_CNT, 0);
        chk("rstmid_done", INIT_DONE, 0);
        chk("rstmid_ready", REQ_READY, 0);
        idle();
        RST = 1'b0;
        wait_done("rstmid_init_len");

        repeat (2) @(posedge CLK);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
